// File: rtl/mux_pkg.sv
// Shared constants and types for the single-bit selector slice and the
// word-wide register-file read mux built from it.
package mux_pkg;

   localparam int N_IN    = 32;
   localparam int SEL_W   = 5;
   localparam int N_NODES = 2 * N_IN - 1;

   typedef logic [SEL_W-1:0] sel_t;

   // Tree depth 0 is the root; deeper levels are steered by lower select bits.
   function automatic int tree_sel_bit(input int depth);
      return SEL_W - 1 - depth;
   endfunction

endpackage : mux_pkg

// File: rtl/mux_2to1.sv
// Two-input single-bit selector cell, the leaf primitive of the selector tree.
module mux_2to1 (
   input  logic A,
   input  logic B,
   input  logic S,
   output logic Y
);

   // NOTE: a full ternary drives Y on every path, so no latch can form.
   assign Y = S ? B : A;

endmodule : mux_2to1

// File: rtl/mux_32to1.sv
// Single-bit 32:1 selector built as a 5-level tree of 2:1 cells, with a
// zero-latency result and an enable-gated registered copy.
module mux_32to1
   import mux_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [N_IN-1:0]  IN,
   input  logic [SEL_W-1:0] SEL,
   output logic             OUT_C,
   output logic             OUT,
   output logic             OUT_VLD
);

   // Heap-ordered tree: node k has children 2k+1 and 2k+2; leaves hold IN.
   logic [N_NODES-1:0] node;

   assign node[N_NODES-1 -: N_IN] = IN;

   for (genvar d = 0; d < SEL_W; d++) begin : g_level
      for (genvar j = 0; j < (1 << d); j++) begin : g_cell
         localparam int K = (1 << d) - 1 + j;
         mux_2to1 u_cell (
            .A (node[2*K+1]),
            .B (node[2*K+2]),
            .S (SEL[tree_sel_bit(d)]),
            .Y (node[K])
         );
      end
   end

   assign OUT_C = node[0];

   // NOTE: non-blocking assignments keep register updates independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OUT     <= 1'b0;
         OUT_VLD <= 1'b0;
      end else if (EN) begin
         OUT     <= OUT_C;
         OUT_VLD <= 1'b1;
      end
   end

endmodule : mux_32to1

// File: tb/tb_mux_32to1.sv
// Scoreboard bench for mux_32to1: stimulus queues expected results, monitors
// compare the combinational output at negedge and the registered output after posedge.
module tb_mux_32to1;

   typedef struct {
      logic  out;
      logic  vld;
      string tag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] din;
   logic [4:0]  sel;
   logic        out_c;
   logic        out_q;
   logic        out_vld;

   logic [31:0] ws_in;
   logic        ws_en;
   wire  [31:0] ws_oc;
   wire  [31:0] ws_o;
   wire  [31:0] ws_vld;

   exp_t comb_q[$];
   exp_t reg_q[$];
   logic m_out;
   logic m_vld;
   int   n_tests;
   int   n_fail;

   mux_32to1 dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .EN      (en),
      .IN      (din),
      .SEL     (sel),
      .OUT_C   (out_c),
      .OUT     (out_q),
      .OUT_VLD (out_vld)
   );

   for (genvar k = 0; k < 32; k++) begin : g_slice
      mux_32to1 u_slice (
         .CLK     (clk),
         .RST_N   (rst_n),
         .EN      (ws_en),
         .IN      (ws_in),
         .SEL     (5'(k)),
         .OUT_C   (ws_oc[k]),
         .OUT     (ws_o[k]),
         .OUT_VLD (ws_vld[k])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; exp_c is the hand-computed selector result.
   task automatic apply(input logic [31:0] d, input int s, input logic e,
                        input logic exp_c, input string tag);
      exp_t c;
      exp_t r;
      @(posedge clk);
      #2;
      din = d;
      sel = 5'(s);
      en  = e;
      c.out = exp_c;
      c.vld = 1'b0;
      c.tag = tag;
      comb_q.push_back(c);
      if (e) begin
         m_out = exp_c;
         m_vld = 1'b1;
      end
      r.out = m_out;
      r.vld = m_vld;
      r.tag = tag;
      reg_q.push_back(r);
   endtask

   // Combinational monitor: mid-cycle, against the queued value and a behavioural index.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check({e.tag, "_out_c"}, 32'(out_c), 32'(e.out));
            check({e.tag, "_model"}, 32'(out_c), 32'(din[sel]));
         end
      end
   end

   // Registered monitor: just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check({e.tag, "_out"}, 32'(out_q), 32'(e.out));
            check({e.tag, "_vld"}, 32'(out_vld), 32'(e.vld));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      n_tests = 0;
      n_fail  = 0;
      m_out   = 1'b0;
      m_vld   = 1'b0;
      rst_n   = 1'b0;
      en      = 1'b0;
      din     = 32'h0;
      sel     = 5'd0;
      ws_en   = 1'b1;
      ws_in   = 32'h0;

      #3;
      check("reset_out", 32'(out_q), 32'h0);
      check("reset_vld", 32'(out_vld), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int j = 0; j < 32; j++) apply(32'h0000_0008, j, 1'b1, j == 3, "sweep");

      apply(32'h0000_0401, 0,  1'b1, 1'b1, "pat_s0");
      apply(32'h0000_0401, 10, 1'b1, 1'b1, "pat_s10");
      apply(32'h0000_0401, 1,  1'b1, 1'b0, "pat_s1");
      apply(32'h0000_0401, 31, 1'b1, 1'b0, "pat_s31");

      for (int j = 0; j < 32; j++) apply(32'hFFFF_FFFF, j, 1'b1, 1'b1, "ones");
      for (int j = 0; j < 32; j++) apply(32'h0000_0000, j, 1'b1, 1'b0, "zeros");

      for (int k = 0; k < 32; k++)
         for (int j = 0; j < 32; j++)
            apply(32'h1 << k, j, 1'b1, k == j, "walk");

      apply(32'h0000_0401, 31, 1'b1, 1'b0, "hold_base");
      apply(32'hFFFF_FFFF, 5,  1'b0, 1'b1, "hold_a");
      apply(32'h0000_0008, 3,  1'b0, 1'b1, "hold_b");
      apply(32'h0000_0008, 3,  1'b1, 1'b1, "enable");
      apply(32'h0000_0000, 17, 1'b0, 1'b0, "hold_c");
      apply(32'h8000_0000, 31, 1'b1, 1'b1, "same_cycle_hi");
      apply(32'h7FFF_FFFF, 31, 1'b1, 1'b0, "same_cycle_lo");

      // Asynchronous reset mid-cycle with OUT holding 1.
      apply(32'h0000_0001, 0, 1'b1, 1'b1, "rst_pre");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      en    = 1'b0;
      m_out = 1'b0;
      m_vld = 1'b0;
      #1;
      check("async_rst_out", 32'(out_q), 32'h0);
      check("async_rst_vld", 32'(out_vld), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply(32'h0000_0001, 0, 1'b0, 1'b1, "post_rst_idle");
      apply(32'h0000_0008, 3, 1'b1, 1'b1, "post_rst_cap");

      // Word slice: 32 selectors with SEL=k reassemble the shared word.
      ws_in = 32'h0000_0401;
      #1;
      check("slice_c_0401", ws_oc, 32'h0000_0401);
      @(posedge clk);
      #1;
      check("slice_q_0401", ws_o, 32'h0000_0401);
      check("slice_vld", ws_vld, 32'hFFFF_FFFF);
      ws_in = 32'hA5C3_0F96;
      #1;
      check("slice_c_a5c3", ws_oc, 32'hA5C3_0F96);
      @(posedge clk);
      #1;
      check("slice_q_a5c3", ws_o, 32'hA5C3_0F96);

      repeat (2) @(posedge clk);
      guard = 0;
      while ((comb_q.size() + reg_q.size()) > 0 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("drain_empty", 32'(comb_q.size() + reg_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux_32to1
